// File: rtl/gpu_cmd_queue_pkg.sv
// rtl/gpu_cmd_queue_pkg.sv - GPU opcode and command-queue shared types
package GPU_OpcodePackage;

  typedef enum logic [4:0] {
    OP_NOP   = 5'h00,
    OP_LOAD  = 5'h01,
    OP_STORE = 5'h02,
    OP_ADD   = 5'h03,
    OP_SUB   = 5'h04,
    OP_MUL   = 5'h05,
    OP_I2F   = 5'h06,
    OP_F2I   = 5'h07,
    OP_JMP   = 5'h08,
    OP_REP   = 5'h09,
    OP_NXI   = 5'h1F
  } GPU_Opcode_enum;

endpackage

package GPU_CmdPackage;
  import GPU_OpcodePackage::*;

  localparam int DATA_W = 16;
  localparam int GPC_W  = 13;
  localparam int AMT_W  = 8;

  typedef struct packed {
    GPU_Opcode_enum    instruction;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] int_to_fp;
    logic [GPC_W-1:0]  gpc_val_s;
    logic [GPC_W-1:0]  gpc_val_i;
    logic [AMT_W-1:0]  inc_a;
    logic [AMT_W-1:0]  inc_b;
    logic [AMT_W-1:0]  repeat_amt;
    logic              capture;
  } gpu_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, RUN} gpu_cmdq_state_e;

endpackage

// File: rtl/gpu_cmd_queue_fifo.sv
// rtl/gpu_cmd_queue_fifo.sv - synchronous FIFO of gpu_cmd_t entries
module gpu_cmd_fifo
  import GPU_CmdPackage::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  gpu_cmd_t                 din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output gpu_cmd_t                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  gpu_cmd_t         mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  // Flush wins over everything; a full queue never accepts even if popping.
  always_comb begin
    do_push   = push && !full && !flush;
    do_pop    = pop && !empty && !flush;
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gpu_cmd_queue.sv
// rtl/gpu_cmd_queue.sv - CPU-to-GPU16 command queue with issue FSM and result capture
module gpu_cmd_queue
  import GPU_OpcodePackage::*;
  import GPU_CmdPackage::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_push,
  input  logic                   cmd_capture,
  input  logic [4:0]             cmd_instruction,
  input  logic [15:0]            cmd_cpu_data,
  input  logic [15:0]            cmd_int_to_fp,
  input  logic [12:0]            cmd_gpc_val_s,
  input  logic [12:0]            cmd_gpc_val_i,
  input  logic [7:0]             cmd_inc_a,
  input  logic [7:0]             cmd_inc_b,
  input  logic [7:0]             cmd_repeat,
  input  logic                   flush,
  input  logic                   result_ack,
  input  logic                   gpu_busy,
  input  logic [15:0]            gpu_data_in,
  input  logic [15:0]            gpu_fp2i_in,
  output logic                   gpu_start,
  output logic [4:0]             instruction,
  output logic [15:0]            cpu_data,
  output logic [15:0]            int_to_fp,
  output logic [12:0]            gpc_val_s,
  output logic [12:0]            gpc_val_i,
  output logic [7:0]             gpc_inc_amount_a,
  output logic [7:0]             gpc_inc_amount_b,
  output logic [7:0]             repeat_op_amount,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   result_valid,
  output logic [15:0]            result_data,
  output logic [15:0]            result_fp2i,
  output logic                   cmd_done,
  output logic                   idle
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  gpu_cmd_t        new_cmd;
  gpu_cmd_t        head;
  gpu_cmdq_state_e state;
  logic [TW-1:0]   ack_cnt;
  logic            cap_r;
  logic            fifo_pop;
  logic            completing;

  always_comb begin
    new_cmd             = '0;
    new_cmd.instruction = GPU_Opcode_enum'(cmd_instruction);
    new_cmd.cpu_data    = cmd_cpu_data;
    new_cmd.int_to_fp   = cmd_int_to_fp;
    new_cmd.gpc_val_s   = cmd_gpc_val_s;
    new_cmd.gpc_val_i   = cmd_gpc_val_i;
    new_cmd.inc_a       = cmd_inc_a;
    new_cmd.inc_b       = cmd_inc_b;
    new_cmd.repeat_amt  = cmd_repeat;
    new_cmd.capture     = cmd_capture;
  end

  gpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (new_cmd),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  assign fifo_pop = (state == IDLE) && !empty;
  assign idle     = (state == IDLE) && empty;

  // A command finishes either when the GPU drops busy in RUN or when it never raised it.
  assign completing = ((state == ACK) && !gpu_busy && (ack_cnt == TW'(ACK_TIMEOUT - 1))) ||
                      ((state == RUN) && !gpu_busy);

  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (cmd_push && full && !flush)
      overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ack_cnt          <= '0;
      cap_r            <= 1'b0;
      gpu_start        <= 1'b0;
      instruction      <= '0;
      cpu_data         <= '0;
      int_to_fp        <= '0;
      gpc_val_s        <= '0;
      gpc_val_i        <= '0;
      gpc_inc_amount_a <= '0;
      gpc_inc_amount_b <= '0;
      repeat_op_amount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            instruction      <= head.instruction;
            cpu_data         <= head.cpu_data;
            int_to_fp        <= head.int_to_fp;
            gpc_val_s        <= head.gpc_val_s;
            gpc_val_i        <= head.gpc_val_i;
            gpc_inc_amount_a <= head.inc_a;
            gpc_inc_amount_b <= head.inc_b;
            repeat_op_amount <= head.repeat_amt;
            cap_r            <= head.capture;
            gpu_start        <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (!gpu_busy) begin
            gpu_start <= 1'b0;
            ack_cnt   <= '0;
            state     <= ACK;
          end
        end
        ACK: begin
          if (gpu_busy)
            state <= RUN;
          else if (completing)
            state <= IDLE;
          else
            ack_cnt <= ack_cnt + 1'b1;
        end
        RUN: begin
          if (!gpu_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture beats a same-cycle acknowledge so a fresh result is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_done     <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_fp2i  <= '0;
    end else begin
      cmd_done <= completing;
      if (completing && cap_r) begin
        result_valid <= 1'b1;
        result_data  <= gpu_data_in;
        result_fp2i  <= gpu_fp2i_in;
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb/tb_gpu_cmd_queue.sv - directed self-checking bench for gpu_cmd_queue
module tb_gpu_cmd_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_push = 1'b0;
  logic        cmd_capture = 1'b0;
  logic [4:0]  cmd_instruction = '0;
  logic [15:0] cmd_cpu_data = '0;
  logic [15:0] cmd_int_to_fp = '0;
  logic [12:0] cmd_gpc_val_s = '0;
  logic [12:0] cmd_gpc_val_i = '0;
  logic [7:0]  cmd_inc_a = '0;
  logic [7:0]  cmd_inc_b = '0;
  logic [7:0]  cmd_repeat = '0;
  logic        flush = 1'b0;
  logic        result_ack = 1'b0;
  logic        gpu_busy = 1'b0;
  logic [15:0] gpu_data_in = '0;
  logic [15:0] gpu_fp2i_in = '0;
  logic        gpu_start;
  logic [4:0]  instruction;
  logic [15:0] cpu_data;
  logic [15:0] int_to_fp;
  logic [12:0] gpc_val_s;
  logic [12:0] gpc_val_i;
  logic [7:0]  gpc_inc_amount_a;
  logic [7:0]  gpc_inc_amount_b;
  logic [7:0]  repeat_op_amount;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        result_valid;
  logic [15:0] result_data;
  logic [15:0] result_fp2i;
  logic        cmd_done;
  logic        idle;

  int checks = 0;
  int failures = 0;

  gpu_cmd_queue #(.DEPTH(8), .ACK_TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_push         (cmd_push),
    .cmd_capture      (cmd_capture),
    .cmd_instruction  (cmd_instruction),
    .cmd_cpu_data     (cmd_cpu_data),
    .cmd_int_to_fp    (cmd_int_to_fp),
    .cmd_gpc_val_s    (cmd_gpc_val_s),
    .cmd_gpc_val_i    (cmd_gpc_val_i),
    .cmd_inc_a        (cmd_inc_a),
    .cmd_inc_b        (cmd_inc_b),
    .cmd_repeat       (cmd_repeat),
    .flush            (flush),
    .result_ack       (result_ack),
    .gpu_busy         (gpu_busy),
    .gpu_data_in      (gpu_data_in),
    .gpu_fp2i_in      (gpu_fp2i_in),
    .gpu_start        (gpu_start),
    .instruction      (instruction),
    .cpu_data         (cpu_data),
    .int_to_fp        (int_to_fp),
    .gpc_val_s        (gpc_val_s),
    .gpc_val_i        (gpc_val_i),
    .gpc_inc_amount_a (gpc_inc_amount_a),
    .gpc_inc_amount_b (gpc_inc_amount_b),
    .repeat_op_amount (repeat_op_amount),
    .full             (full),
    .empty            (empty),
    .count            (count),
    .overflow         (overflow),
    .result_valid     (result_valid),
    .result_data      (result_data),
    .result_fp2i      (result_fp2i),
    .cmd_done         (cmd_done),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    gpu_busy = 1'b0;
    cmd_push = 1'b0;
    flush = 1'b0;
    result_ack = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [4:0] op, input logic [15:0] data, input logic cap);
    cmd_instruction = op;
    cmd_cpu_data    = data;
    cmd_int_to_fp   = ~data;
    cmd_gpc_val_s   = data[12:0];
    cmd_gpc_val_i   = ~data[12:0];
    cmd_inc_a       = 8'h11;
    cmd_inc_b       = 8'h22;
    cmd_repeat      = 8'h5A;
    cmd_capture     = cap;
    cmd_push        = 1'b1;
    tick;
    cmd_push        = 1'b0;
  endtask

  // Issue one command against an idle GPU that is busy for a single cycle.
  task automatic drive_cmd(input logic cap, input logic [15:0] gd, input logic [15:0] gf, input logic ack);
    push_cmd(5'h03, 16'h00AA, cap);
    tick;
    tick;
    gpu_busy = 1'b1;
    tick;
    gpu_busy = 1'b0;
    gpu_data_in = gd;
    gpu_fp2i_in = gf;
    result_ack = ack;
    tick;
    result_ack = 1'b0;
    gpu_data_in = '0;
    gpu_fp2i_in = '0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (gpu_start !== 1'b0) begin failures++; $display("FAIL reset_gpu_start got=%b exp=0", gpu_start); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (overflow !== 1'b0 || result_valid !== 1'b0 || cmd_done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", overflow, result_valid, cmd_done); end
    checks++; if (cpu_data !== 16'h0 || instruction !== 5'h0 || result_data !== 16'h0) begin failures++; $display("FAIL reset_fields got=%h %h %h exp=0", cpu_data, instruction, result_data); end
  endtask

  task automatic test_single;
    do_reset;
    push_cmd(5'h03, 16'h1234, 1'b0);
    checks++; if (count !== 4'd1 || gpu_start !== 1'b0) begin failures++; $display("FAIL single_push got count=%0d start=%b exp=1,0", count, gpu_start); end
    tick;
    checks++; if (gpu_start !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL single_issue got start=%b count=%0d exp=1,0", gpu_start, count); end
    checks++; if (cpu_data !== 16'h1234 || instruction !== 5'h03) begin failures++; $display("FAIL single_fields got=%h/%h exp=1234/03", cpu_data, instruction); end
    checks++; if (gpc_val_s !== 13'h1234 || int_to_fp !== 16'hEDCB || repeat_op_amount !== 8'h5A || gpc_inc_amount_b !== 8'h22) begin failures++; $display("FAIL single_aux got=%h %h %h %h exp=1234 edcb 5a 22", gpc_val_s, int_to_fp, repeat_op_amount, gpc_inc_amount_b); end
    tick;
    checks++; if (gpu_start !== 1'b0) begin failures++; $display("FAIL single_start_one_cycle got=%b exp=0", gpu_start); end
    gpu_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (cmd_done !== 1'b0 || gpu_start !== 1'b0) begin failures++; $display("FAIL single_busy_phase cyc=%0d got done=%b start=%b exp=0,0", i, cmd_done, gpu_start); end
    end
    gpu_busy = 1'b0;
    tick;
    checks++; if (cmd_done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", cmd_done); end
    tick;
    checks++; if (cmd_done !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL single_after got done=%b idle=%b exp=0,1", cmd_done, idle); end
  endtask

  task automatic test_overflow;
    do_reset;
    gpu_busy = 1'b1;
    push_cmd(5'h01, 16'h0F00, 1'b0);
    tick;
    for (int i = 0; i < 8; i++) begin
      push_cmd(5'h02, 16'(i), 1'b0);
      if (i == 6) begin
        checks++; if (full !== 1'b0 || count !== 4'd7) begin failures++; $display("FAIL ovf_seven got full=%b count=%0d exp=0,7", full, count); end
      end
    end
    checks++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got full=%b count=%0d ovf=%b exp=1,8,0", full, count, overflow); end
    push_cmd(5'h02, 16'h0099, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_drop got ovf=%b count=%0d exp=1,8", overflow, count); end
    checks++; if (gpu_start !== 1'b1 || cpu_data !== 16'h0F00) begin failures++; $display("FAIL ovf_hold_issue got start=%b data=%h exp=1,0f00", gpu_start, cpu_data); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (overflow !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL ovf_reset got ovf=%b full=%b exp=0,0", overflow, full); end
  endtask

  task automatic test_order;
    logic [15:0] issued [3];
    int n_iss = 0;
    int done_cnt = 0;
    int busy_left = 0;
    bit accepting = 0;
    do_reset;
    gpu_busy = 1'b1;
    push_cmd(5'h03, 16'h0001, 1'b0);
    push_cmd(5'h03, 16'h0002, 1'b0);
    push_cmd(5'h03, 16'h0003, 1'b0);
    for (int cyc = 0; cyc < 200 && done_cnt < 3; cyc++) begin
      if (accepting) busy_left = 5;
      accepting = 0;
      gpu_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (gpu_start && !gpu_busy) begin
        if (n_iss < 3) issued[n_iss] = cpu_data;
        n_iss++;
        accepting = 1;
      end
      tick;
      if (cmd_done) done_cnt++;
    end
    gpu_busy = 1'b0;
    tick;
    checks++; if (done_cnt !== 3 || n_iss !== 3) begin failures++; $display("FAIL order_counts got done=%0d issued=%0d exp=3,3", done_cnt, n_iss); end
    for (int i = 0; i < 3 && i < n_iss; i++) begin
      checks++; if (issued[i] !== 16'(i + 1)) begin failures++; $display("FAIL order_seq idx=%0d got=%h exp=%h", i, issued[i], 16'(i + 1)); end
    end
    checks++; if (empty !== 1'b1 || idle !== 1'b1) begin failures++; $display("FAIL order_end got empty=%b idle=%b exp=1,1", empty, idle); end
  endtask

  task automatic test_capture;
    do_reset;
    drive_cmd(1'b1, 16'hBEEF, 16'h0042, 1'b0);
    checks++; if (cmd_done !== 1'b1 || result_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got done=%b valid=%b exp=1,1", cmd_done, result_valid); end
    checks++; if (result_data !== 16'hBEEF || result_fp2i !== 16'h0042) begin failures++; $display("FAIL cap_values got=%h/%h exp=beef/0042", result_data, result_fp2i); end
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL cap_ack got=%b exp=0", result_valid); end
    drive_cmd(1'b0, 16'h1111, 16'h2222, 1'b0);
    checks++; if (cmd_done !== 1'b1 || result_valid !== 1'b0 || result_data !== 16'hBEEF || result_fp2i !== 16'h0042) begin failures++; $display("FAIL cap_nocapture got done=%b valid=%b data=%h fp=%h exp=1,0,beef,0042", cmd_done, result_valid, result_data, result_fp2i); end
    drive_cmd(1'b1, 16'hCAFE, 16'h0007, 1'b1);
    checks++; if (result_valid !== 1'b1 || result_data !== 16'hCAFE || result_fp2i !== 16'h0007) begin failures++; $display("FAIL cap_ack_collision got valid=%b data=%h fp=%h exp=1,cafe,0007", result_valid, result_data, result_fp2i); end
  endtask

  task automatic test_timeout;
    do_reset;
    push_cmd(5'h1F, 16'h000A, 1'b0);
    push_cmd(5'h03, 16'h000B, 1'b0);
    checks++; if (gpu_start !== 1'b1 || cpu_data !== 16'h000A || count !== 4'd1) begin failures++; $display("FAIL to_first got start=%b data=%h count=%0d exp=1,000a,1", gpu_start, cpu_data, count); end
    tick;
    checks++; if (gpu_start !== 1'b0) begin failures++; $display("FAIL to_accept got=%b exp=0", gpu_start); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (cmd_done !== 1'b0) begin failures++; $display("FAIL to_early_done cyc=%0d got=%b exp=0", i, cmd_done); end
    end
    tick;
    checks++; if (cmd_done !== 1'b1) begin failures++; $display("FAIL to_done got=%b exp=1", cmd_done); end
    tick;
    checks++; if (gpu_start !== 1'b1 || cpu_data !== 16'h000B || empty !== 1'b1) begin failures++; $display("FAIL to_next got start=%b data=%h empty=%b exp=1,000b,1", gpu_start, cpu_data, empty); end
  endtask

  task automatic test_reset_flush;
    do_reset;
    push_cmd(5'h03, 16'h0100, 1'b1);
    tick;
    tick;
    gpu_busy = 1'b1;
    tick;
    push_cmd(5'h03, 16'h0101, 1'b0);
    push_cmd(5'h03, 16'h0102, 1'b0);
    push_cmd(5'h03, 16'h0103, 1'b0);
    checks++; if (count !== 4'd3 || gpu_start !== 1'b0) begin failures++; $display("FAIL rf_run_queued got count=%0d start=%b exp=3,0", count, gpu_start); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    gpu_busy = 1'b0;
    checks++; if (count !== 4'd0 || gpu_start !== 1'b0 || empty !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL rf_midreset got count=%0d start=%b empty=%b valid=%b exp=0,0,1,0", count, gpu_start, empty, result_valid); end
    tick;
    checks++; if (idle !== 1'b1 || gpu_start !== 1'b0) begin failures++; $display("FAIL rf_reset_idle got idle=%b start=%b exp=1,0", idle, gpu_start); end
    gpu_busy = 1'b1;
    push_cmd(5'h03, 16'h0200, 1'b0);
    push_cmd(5'h03, 16'h0201, 1'b0);
    push_cmd(5'h03, 16'h0202, 1'b0);
    checks++; if (count !== 4'd2 || gpu_start !== 1'b1) begin failures++; $display("FAIL rf_preflush got count=%0d start=%b exp=2,1", count, gpu_start); end
    flush = 1'b1;
    push_cmd(5'h03, 16'h0203, 1'b0);
    flush = 1'b0;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL rf_flush got count=%0d empty=%b exp=0,1", count, empty); end
    checks++; if (gpu_start !== 1'b1 || cpu_data !== 16'h0200) begin failures++; $display("FAIL rf_flush_inflight got start=%b data=%h exp=1,0200", gpu_start, cpu_data); end
    gpu_busy = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    checks++; if (gpu_start !== 1'b0 || idle !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL rf_drain got start=%b idle=%b count=%0d exp=0,1,0", gpu_start, idle, count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_order;
    test_capture;
    test_timeout;
    test_reset_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
